// File: rtl/qa_driver_csr_mgr.sv
// rtl/qa_driver_csr_mgr.sv - QA driver CSR front end: DSM base, SREG request channels, MMIO-compat queue, response arbiter
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   csr_wr_valid/addr/data                host CSR write strobe (one cycle per write)
//   dsm_base, dsm_base_valid              committed 64-bit DSM base
//   sreg_req_valid/addr/ready             per-channel SREG request handshake (addr packed N x 32)
//   sreg_rsp_valid/data/ready             per-channel SREG response handshake (data packed N x 64)
//   rsp_out_valid/ready/chan/data         arbitrated response stream toward the DSM writer
//   mmio_rd_valid/ready/addr              MMIO-compat request queue head
//   err_overflow                          sticky drop flags, bit N is the MMIO queue
module qa_driver_csr_mgr #(
    parameter logic [15:0] CSR_BASE          = 16'h1a00,
    parameter int          N_SREG_CHANNELS   = 2,
    parameter int          MMIO_COMPAT_DEPTH = 4,
    parameter bit          LEGACY_ALIAS      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         csr_wr_valid,
    input  logic [15:0]                  csr_wr_addr,
    input  logic [31:0]                  csr_wr_data,
    output logic [63:0]                  dsm_base,
    output logic                         dsm_base_valid,
    output logic [N_SREG_CHANNELS-1:0]   sreg_req_valid,
    output logic [N_SREG_CHANNELS*32-1:0] sreg_req_addr,
    input  logic [N_SREG_CHANNELS-1:0]   sreg_req_ready,
    input  logic [N_SREG_CHANNELS-1:0]   sreg_rsp_valid,
    input  logic [N_SREG_CHANNELS*64-1:0] sreg_rsp_data,
    output logic [N_SREG_CHANNELS-1:0]   sreg_rsp_ready,
    output logic                         rsp_out_valid,
    input  logic                         rsp_out_ready,
    output logic [2:0]                   rsp_out_chan,
    output logic [63:0]                  rsp_out_data,
    output logic                         mmio_rd_valid,
    input  logic                         mmio_rd_ready,
    output logic [15:0]                  mmio_rd_addr,
    output logic [N_SREG_CHANNELS:0]     err_overflow
);

    localparam int N  = N_SREG_CHANNELS;
    localparam int AW = $clog2(MMIO_COMPAT_DEPTH);

    localparam logic [15:0] A_DSM_LO = CSR_BASE;
    localparam logic [15:0] A_DSM_HI = CSR_BASE + 16'h0004;
    localparam logic [15:0] A_ALIAS  = CSR_BASE + 16'h0010;
    localparam logic [15:0] A_MMIO   = CSR_BASE + 16'h0014;
    localparam logic [15:0] A_CLEAR  = CSR_BASE + 16'h0018;

    typedef enum logic {S_IDLE, S_PEND} sreg_state_t;

    // ---------------- CSR decode ----------------
    logic wr_dsm_lo, wr_dsm_hi, wr_mmio, wr_clr;
    logic [N-1:0] wr_sreg;
    logic [N-1:0] sreg_drop;

    assign wr_dsm_lo = csr_wr_valid && (csr_wr_addr == A_DSM_LO);
    assign wr_dsm_hi = csr_wr_valid && (csr_wr_addr == A_DSM_HI);
    assign wr_mmio   = csr_wr_valid && (csr_wr_addr == A_MMIO);
    assign wr_clr    = csr_wr_valid && (csr_wr_addr == A_CLEAR);

    // ---------------- DSM base ----------------
    logic [31:0] dsm_lo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsm_lo_q       <= '0;
            dsm_base       <= '0;
            dsm_base_valid <= 1'b0;
        end else begin
            if (wr_dsm_lo) dsm_lo_q <= csr_wr_data;
            // Low half only becomes visible when the high half commits.
            if (wr_dsm_hi) begin
                dsm_base       <= {csr_wr_data, dsm_lo_q};
                dsm_base_valid <= 1'b1;
            end
        end
    end

    // ---------------- SREG request channels ----------------
    for (genvar k = 0; k < N; k++) begin : g_sreg
        localparam logic [15:0] CH_ADDR   = CSR_BASE + 16'h0040 + 16'(4 * k);
        localparam bit          ALIAS_ON  = (k == 0) && LEGACY_ALIAS;

        sreg_state_t state_q;
        logic [31:0] addr_q;

        assign wr_sreg[k] = csr_wr_valid &&
                            ((csr_wr_addr == CH_ADDR) || (ALIAS_ON && (csr_wr_addr == A_ALIAS)));
        // A write in PEND is dropped even if the client accepts in the same cycle.
        assign sreg_drop[k] = wr_sreg[k] && (state_q == S_PEND);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                addr_q  <= '0;
            end else if (state_q == S_IDLE) begin
                if (wr_sreg[k]) begin
                    addr_q  <= csr_wr_data;
                    state_q <= S_PEND;
                end
            end else begin
                if (sreg_req_ready[k]) state_q <= S_IDLE;
            end
        end

        assign sreg_req_valid[k]          = (state_q == S_PEND);
        assign sreg_req_addr[k*32 +: 32]  = addr_q;
    end

    // ---------------- MMIO-compat queue ----------------
    logic [15:0]   fifo_mem [MMIO_COMPAT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, mmio_pop, mmio_push, mmio_drop;

    assign fifo_full     = (count == (AW+1)'(MMIO_COMPAT_DEPTH));
    assign mmio_rd_valid = (count != '0);
    assign mmio_pop      = mmio_rd_valid && mmio_rd_ready;
    // A pop in the same cycle frees the slot for a push into a full queue.
    assign mmio_push     = wr_mmio && (!fifo_full || mmio_pop);
    assign mmio_drop     = wr_mmio && fifo_full && !mmio_pop;
    assign mmio_rd_addr  = mmio_rd_valid ? fifo_mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MMIO_COMPAT_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (mmio_push) begin
                fifo_mem[wr_ptr] <= csr_wr_data[15:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (mmio_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({mmio_push, mmio_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- Sticky overflow flags ----------------
    logic [N:0] err_set, err_clr;

    assign err_set = {mmio_drop, sreg_drop};
    assign err_clr = wr_clr ? csr_wr_data[N:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_overflow <= '0;
        else          err_overflow <= (err_overflow & ~err_clr) | err_set;  // set wins
    end

    // ---------------- Response arbiter ----------------
    logic [2:0]  prio_q;
    logic [2:0]  arb_win;
    logic        arb_found, arb_load;
    logic [63:0] arb_data;
    int          rank, best_rank;

    // Rank each channel by its distance from the priority pointer; lowest valid rank wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_data  = '0;
        rank      = 0;
        best_rank = N;
        for (int j = 0; j < N; j++) begin
            rank = (j + N - int'(prio_q)) % N;
            if (sreg_rsp_valid[j] && (rank < best_rank)) begin
                best_rank = rank;
                arb_found = 1'b1;
                arb_win   = 3'(j);
                arb_data  = sreg_rsp_data[j*64 +: 64];
            end
        end
    end

    assign arb_load = arb_found && (!rsp_out_valid || rsp_out_ready);

    always_comb begin
        sreg_rsp_ready = '0;
        for (int j = 0; j < N; j++) sreg_rsp_ready[j] = arb_load && (arb_win == 3'(j));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q        <= '0;
            rsp_out_valid <= 1'b0;
            rsp_out_chan  <= '0;
            rsp_out_data  <= '0;
        end else if (arb_load) begin
            rsp_out_valid <= 1'b1;
            rsp_out_chan  <= arb_win;
            rsp_out_data  <= arb_data;
            prio_q        <= (arb_win == 3'(N - 1)) ? 3'd0 : arb_win + 3'd1;
        end else if (rsp_out_ready) begin
            rsp_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qa_driver_csr_mgr.sv
// tb/tb_qa_driver_csr_mgr.sv - self-checking bench for qa_driver_csr_mgr
module tb_qa_driver_csr_mgr;
    localparam int N = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             csr_wr_valid = 1'b0;
    logic [15:0]      csr_wr_addr = '0;
    logic [31:0]      csr_wr_data = '0;
    logic [63:0]      dsm_base;
    logic             dsm_base_valid;
    logic [N-1:0]     sreg_req_valid;
    logic [N*32-1:0]  sreg_req_addr;
    logic [N-1:0]     sreg_req_ready = '0;
    logic [N-1:0]     sreg_rsp_valid = '0;
    logic [N*64-1:0]  sreg_rsp_data = '0;
    logic [N-1:0]     sreg_rsp_ready;
    logic             rsp_out_valid;
    logic             rsp_out_ready = 1'b0;
    logic [2:0]       rsp_out_chan;
    logic [63:0]      rsp_out_data;
    logic             mmio_rd_valid;
    logic             mmio_rd_ready = 1'b0;
    logic [15:0]      mmio_rd_addr;
    logic [N:0]       err_overflow;

    logic [63:0]  d2_dsm_base;
    logic         d2_dsm_base_valid;
    logic [1:0]   d2_sreg_req_valid;
    logic [63:0]  d2_sreg_req_addr;
    logic [1:0]   d2_sreg_rsp_ready;
    logic         d2_rsp_out_valid;
    logic [2:0]   d2_rsp_out_chan;
    logic [63:0]  d2_rsp_out_data;
    logic         d2_mmio_rd_valid;
    logic [15:0]  d2_mmio_rd_addr;
    logic [2:0]   d2_err_overflow;

    always #5 clk = ~clk;

    qa_driver_csr_mgr #(.CSR_BASE(16'h1a00), .N_SREG_CHANNELS(N), .MMIO_COMPAT_DEPTH(4), .LEGACY_ALIAS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .dsm_base(dsm_base), .dsm_base_valid(dsm_base_valid),
        .sreg_req_valid(sreg_req_valid), .sreg_req_addr(sreg_req_addr), .sreg_req_ready(sreg_req_ready),
        .sreg_rsp_valid(sreg_rsp_valid), .sreg_rsp_data(sreg_rsp_data), .sreg_rsp_ready(sreg_rsp_ready),
        .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready),
        .rsp_out_chan(rsp_out_chan), .rsp_out_data(rsp_out_data),
        .mmio_rd_valid(mmio_rd_valid), .mmio_rd_ready(mmio_rd_ready), .mmio_rd_addr(mmio_rd_addr),
        .err_overflow(err_overflow)
    );

    qa_driver_csr_mgr #(.CSR_BASE(16'h1a00), .N_SREG_CHANNELS(2), .MMIO_COMPAT_DEPTH(4), .LEGACY_ALIAS(1'b0)) dut_noalias (
        .clk(clk), .reset_n(reset_n),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .dsm_base(d2_dsm_base), .dsm_base_valid(d2_dsm_base_valid),
        .sreg_req_valid(d2_sreg_req_valid), .sreg_req_addr(d2_sreg_req_addr), .sreg_req_ready(2'b11),
        .sreg_rsp_valid(2'b00), .sreg_rsp_data(128'h0), .sreg_rsp_ready(d2_sreg_rsp_ready),
        .rsp_out_valid(d2_rsp_out_valid), .rsp_out_ready(1'b1),
        .rsp_out_chan(d2_rsp_out_chan), .rsp_out_data(d2_rsp_out_data),
        .mmio_rd_valid(d2_mmio_rd_valid), .mmio_rd_ready(1'b1), .mmio_rd_addr(d2_mmio_rd_addr),
        .err_overflow(d2_err_overflow)
    );

    typedef struct packed {
        logic [2:0]  chan;
        logic [63:0] data;
    } rsp_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] mmio_q[$];
    rsp_t        rsp_q[$];
    logic [63:0] exp_dsm = '0;

    task automatic csr_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = a;
        csr_wr_data  = d;
        @(negedge clk);
        csr_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mmio_q.delete();
        rsp_q.delete();
        exp_dsm = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (dsm_base !== 64'h0 || dsm_base_valid !== 1'b0) begin failures++; $display("FAIL reset_dsm got=%h/%b exp=0/0", dsm_base, dsm_base_valid); end
        checks++; if (sreg_req_valid !== '0 || sreg_req_addr !== '0) begin failures++; $display("FAIL reset_sreg got=%b/%h exp=0/0", sreg_req_valid, sreg_req_addr); end
        checks++; if (rsp_out_valid !== 1'b0 || rsp_out_chan !== 3'd0 || rsp_out_data !== 64'h0) begin failures++; $display("FAIL reset_rsp got=%b/%0d/%h exp=0", rsp_out_valid, rsp_out_chan, rsp_out_data); end
        checks++; if (mmio_rd_valid !== 1'b0 || mmio_rd_addr !== 16'h0 || err_overflow !== '0) begin failures++; $display("FAIL reset_mmio_err got=%b/%h/%b exp=0", mmio_rd_valid, mmio_rd_addr, err_overflow); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dsm();
        csr_write(16'h1a00, 32'h89ABCDEF);
        checks++; if (dsm_base_valid !== 1'b0) begin failures++; $display("FAIL dsm_lo_no_commit got=%b exp=0", dsm_base_valid); end
        csr_write(16'h1a04, 32'h01234567);
        exp_dsm = 64'h0123456789ABCDEF;
        checks++; if (dsm_base !== exp_dsm || dsm_base_valid !== 1'b1) begin failures++; $display("FAIL dsm_commit got=%h/%b exp=%h/1", dsm_base, dsm_base_valid, exp_dsm); end
        csr_write(16'h1a00, 32'hFFFF0000);
        checks++; if (dsm_base !== exp_dsm || dsm_base_valid !== 1'b1) begin failures++; $display("FAIL dsm_lo_after_commit got=%h exp=%h", dsm_base, exp_dsm); end
    endtask

    task automatic test_sreg_backpressure();
        sreg_req_ready = '0;
        csr_write(16'h1a44, 32'h55);
        checks++; if (sreg_req_valid[1] !== 1'b1 || sreg_req_addr[63:32] !== 32'h55) begin failures++; $display("FAIL sreg1_first got=%b/%h exp=1/55", sreg_req_valid[1], sreg_req_addr[63:32]); end
        csr_write(16'h1a44, 32'h66);
        checks++; if (sreg_req_addr[63:32] !== 32'h55 || err_overflow !== 4'b0010) begin failures++; $display("FAIL sreg1_drop got=%h/%b exp=55/0010", sreg_req_addr[63:32], err_overflow); end
        sreg_req_ready = 3'b010;
        @(negedge clk);
        sreg_req_ready = '0;
        checks++; if (sreg_req_valid !== 3'b000) begin failures++; $display("FAIL sreg1_accept got=%b exp=000", sreg_req_valid); end
        csr_write(16'h1a18, 32'h2);
        checks++; if (err_overflow !== 4'b0000) begin failures++; $display("FAIL sreg1_clear got=%b exp=0000", err_overflow); end
    endtask

    task automatic test_accept_collision();
        sreg_req_ready = '0;
        csr_write(16'h1a40, 32'h11);
        sreg_req_ready = 3'b001;
        csr_wr_valid   = 1'b1;
        csr_wr_addr    = 16'h1a40;
        csr_wr_data    = 32'h22;
        @(negedge clk);
        csr_wr_valid   = 1'b0;
        sreg_req_ready = '0;
        checks++; if (sreg_req_valid[0] !== 1'b0 || err_overflow[0] !== 1'b1 || sreg_req_addr[31:0] !== 32'h11) begin
            failures++; $display("FAIL collision got=%b/%b/%h exp=0/1/11", sreg_req_valid[0], err_overflow[0], sreg_req_addr[31:0]); end
        csr_write(16'h1a18, 32'h1);
        checks++; if (err_overflow !== 4'b0000) begin failures++; $display("FAIL collision_clear got=%b exp=0000", err_overflow); end
    endtask

    task automatic test_back_to_back_sreg();
        sreg_req_ready = 3'b100;
        for (int i = 0; i < 3; i++) begin
            csr_write(16'h1a48, 32'hA0 + 32'(i));
            checks++; if (sreg_req_valid[2] !== 1'b1 || sreg_req_addr[95:64] !== 32'hA0 + 32'(i) || err_overflow[2] !== 1'b0) begin
                failures++; $display("FAIL b2b_sreg%0d got=%b/%h/%b exp=1/%h/0", i, sreg_req_valid[2], sreg_req_addr[95:64], err_overflow[2], 32'hA0 + 32'(i)); end
        end
        @(negedge clk);
        checks++; if (sreg_req_valid[2] !== 1'b0) begin failures++; $display("FAIL b2b_sreg_idle got=%b exp=0", sreg_req_valid[2]); end
        sreg_req_ready = '0;
    endtask

    task automatic test_legacy_alias();
        csr_write(16'h1a10, 32'h7);
        checks++; if (sreg_req_valid[0] !== 1'b1 || sreg_req_addr[31:0] !== 32'h7) begin failures++; $display("FAIL alias_on got=%b/%h exp=1/7", sreg_req_valid[0], sreg_req_addr[31:0]); end
        checks++; if (d2_sreg_req_valid !== 2'b00) begin failures++; $display("FAIL alias_off got=%b exp=00", d2_sreg_req_valid); end
        sreg_req_ready = 3'b001;
        @(negedge clk);
        sreg_req_ready = '0;
        csr_write(16'h1a40, 32'h9);
        checks++; if (d2_sreg_req_valid !== 2'b01 || d2_sreg_req_addr[31:0] !== 32'h9) begin failures++; $display("FAIL noalias_ch0 got=%b/%h exp=01/9", d2_sreg_req_valid, d2_sreg_req_addr[31:0]); end
        sreg_req_ready = 3'b001;
        @(negedge clk);
        sreg_req_ready = '0;
    endtask

    task automatic test_ignored();
        csr_write(16'h1a4c, 32'h1);
        csr_write(16'h1a08, 32'h1);
        csr_write(16'h1b00, 32'h1);
        checks++; if (sreg_req_valid !== '0 || err_overflow !== '0 || mmio_rd_valid !== 1'b0 || dsm_base !== exp_dsm) begin
            failures++; $display("FAIL ignored got=%b/%b/%b/%h exp=0/0/0/%h", sreg_req_valid, err_overflow, mmio_rd_valid, dsm_base, exp_dsm); end
    endtask

    task automatic mmio_drain(input string tag);
        int n;
        n = mmio_q.size();
        mmio_rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++; if (mmio_rd_valid !== 1'b1 || mmio_rd_addr !== mmio_q[0]) begin failures++; $display("FAIL %s_pop%0d got=%b/%h exp=1/%h", tag, i, mmio_rd_valid, mmio_rd_addr, mmio_q[0]); end
            void'(mmio_q.pop_front());
            @(negedge clk);
        end
        mmio_rd_ready = 1'b0;
        checks++; if (mmio_rd_valid !== 1'b0) begin failures++; $display("FAIL %s_empty got=%b exp=0", tag, mmio_rd_valid); end
    endtask

    task automatic test_mmio_overflow();
        logic exp_ovf;
        exp_ovf = 1'b0;
        mmio_rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            csr_write(16'h1a14, 32'h100 + 32'(i));
            if (mmio_q.size() < 4) mmio_q.push_back(16'h100 + 16'(i));
            else exp_ovf = 1'b1;
            if (i == 0) begin
                checks++; if (mmio_rd_valid !== 1'b1 || mmio_rd_addr !== 16'h100) begin failures++; $display("FAIL mmio_first got=%b/%h exp=1/100", mmio_rd_valid, mmio_rd_addr); end
            end
        end
        checks++; if (err_overflow[N] !== exp_ovf) begin failures++; $display("FAIL mmio_ovf got=%b exp=%b", err_overflow[N], exp_ovf); end
        mmio_drain("mmio_ovf");
        csr_write(16'h1a18, 32'h8);
        checks++; if (err_overflow !== '0) begin failures++; $display("FAIL mmio_clear got=%b exp=0000", err_overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            csr_write(16'h1a14, 32'h200 + 32'(i));
            mmio_q.push_back(16'h200 + 16'(i));
        end
        mmio_rd_ready = 1'b1;
        csr_wr_valid  = 1'b1;
        csr_wr_addr   = 16'h1a14;
        csr_wr_data   = 32'h204;
        checks++; if (mmio_rd_addr !== mmio_q[0]) begin failures++; $display("FAIL fullpp_head got=%h exp=%h", mmio_rd_addr, mmio_q[0]); end
        void'(mmio_q.pop_front());
        mmio_q.push_back(16'h204);
        @(negedge clk);
        csr_wr_valid  = 1'b0;
        mmio_rd_ready = 1'b0;
        checks++; if (err_overflow[N] !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", err_overflow[N]); end
        mmio_drain("fullpp");
    endtask

    task automatic test_arbiter();
        logic [N-1:0] pat   [17];
        logic         rdy   [17];
        logic [63:0]  cur_data [N];
        logic [2:0]   grants[$];
        logic [2:0]   exp_grants [6];
        logic [N-1:0] exp_ready;
        int           rr;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            pat[c] = (c < 12) ? 3'b111 : (c < 14) ? 3'b100 : 3'b000;
            rdy[c] = !(c >= 6 && c < 9);
        end
        for (int k = 0; k < N; k++) cur_data[k] = 64'hD0D0_0000_0000_0000 + (64'(k) << 40);
        exp_grants = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        rr = 0;
        for (int c = 0; c < 17; c++) begin
            sreg_rsp_valid = pat[c];
            for (int k = 0; k < N; k++) sreg_rsp_data[k*64 +: 64] = cur_data[k];
            rsp_out_ready = rdy[c];
            if (rsp_q.size() > 0) begin
                checks++; if (rsp_out_valid !== 1'b1 || rsp_out_chan !== rsp_q[0].chan || rsp_out_data !== rsp_q[0].data) begin
                    failures++; $display("FAIL arb_out_c%0d got=%b/%0d/%h exp=1/%0d/%h", c, rsp_out_valid, rsp_out_chan, rsp_out_data, rsp_q[0].chan, rsp_q[0].data); end
                if (rdy[c]) begin
                    grants.push_back(rsp_out_chan);
                    void'(rsp_q.pop_front());
                end
            end else begin
                checks++; if (rsp_out_valid !== 1'b0) begin failures++; $display("FAIL arb_idle_c%0d got=%b exp=0", c, rsp_out_valid); end
            end
            exp_ready = '0;
            if (rsp_q.size() == 0) begin
                for (int i = 0; i < N; i++) begin
                    int g;
                    g = (rr + i) % N;
                    if (exp_ready == '0 && pat[c][g]) begin
                        exp_ready[g] = 1'b1;
                        rsp_q.push_back('{chan: 3'(g), data: cur_data[g]});
                        cur_data[g] = cur_data[g] + 64'h1;
                        rr = (g + 1) % N;
                    end
                end
            end
            #1;
            checks++; if (sreg_rsp_ready !== exp_ready) begin failures++; $display("FAIL arb_ready_c%0d got=%b exp=%b", c, sreg_rsp_ready, exp_ready); end
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (grants.size() <= i || grants[i] !== exp_grants[i]) begin
                failures++; $display("FAIL arb_fair%0d got=%0d exp=%0d", i, (grants.size() > i) ? grants[i] : 3'd7, exp_grants[i]); end
        end
        sreg_rsp_valid = '0;
        rsp_out_ready  = 1'b0;
    endtask

    task automatic test_async_reset();
        sreg_req_ready = '0;
        csr_write(16'h1a04, 32'hCAFE);
        csr_write(16'h1a40, 32'h33);
        csr_write(16'h1a14, 32'h55);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sreg_req_valid !== '0 || sreg_req_addr !== '0 || mmio_rd_valid !== 1'b0 || dsm_base_valid !== 1'b0 || dsm_base !== 64'h0) begin
            failures++; $display("FAIL async_reset got=%b/%h/%b/%b/%h exp=0", sreg_req_valid, sreg_req_addr, mmio_rd_valid, dsm_base_valid, dsm_base); end
        @(negedge clk);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 16'h1a04;
        csr_wr_data  = 32'h1;
        @(negedge clk);
        csr_wr_valid = 1'b0;
        checks++; if (dsm_base_valid !== 1'b0 || sreg_req_valid !== '0) begin failures++; $display("FAIL reset_held got=%b/%b exp=0/0", dsm_base_valid, sreg_req_valid); end
        reset_n = 1'b1;
        mmio_q.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dsm();
        test_sreg_backpressure();
        test_accept_collision();
        test_back_to_back_sreg();
        test_legacy_alias();
        test_ignored();
        test_mmio_overflow();
        test_full_push_pop();
        test_arbiter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
